// File: rtl/sync_fifo_chk.sv
`default_nettype none
// sync_fifo_chk: single-clock storage FIFO with push/pop protocol checking, sticky error flags
// and saturating violation counters. Define FIFO_ASSERT_EN to elaborate clocked interface assertions.
module sync_fifo_chk #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2,
  parameter int CW    = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr,
  output logic [CW-1:0]              ovf_cnt,
  output logic [CW-1:0]              udf_cnt
);

  localparam int              CNTW     = $clog2(DEPTH + 1);
  localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNTW-1:0] DEPTH_C  = CNTW'(DEPTH);
  localparam logic [CNTW-1:0] AF_C     = CNTW'(AF_TH);
  localparam logic [CNTW-1:0] AE_C     = CNTW'(AE_TH);
  localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0]   CNT_MAX  = '1;
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rp;
  logic [AW-1:0]    wp;
  logic             pop_ok;
  logic             push_ok;
  logic             push_rej;
  logic             pop_rej;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A pop on a full FIFO frees the slot the simultaneous push needs; empty never bypasses.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    push_rej = push && !push_ok;
    pop_rej  = pop && empty;
  end

  always_ff @(posedge clk) begin
    if (rstn && push_ok) begin
      mem[wp] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rp        <= '0;
      wp        <= '0;
      count     <= '0;
      rdata     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ovf_cnt   <= '0;
      udf_cnt   <= '0;
    end else begin
      if (push_ok) begin
        wp <= (wp == LAST_PTR) ? '0 : wp + 1'b1;
      end
      if (pop_ok) begin
        rdata <= mem[rp];
        rp    <= (rp == LAST_PTR) ? '0 : rp + 1'b1;
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // A violation in the same cycle as err_clr wins: flag set, counter restarts at one.
      if (push_rej) begin
        overflow <= 1'b1;
        if (err_clr)                ovf_cnt <= CNT_ONE;
        else if (ovf_cnt != CNT_MAX) ovf_cnt <= ovf_cnt + 1'b1;
      end else if (err_clr) begin
        overflow <= 1'b0;
        ovf_cnt  <= '0;
      end

      if (pop_rej) begin
        underflow <= 1'b1;
        if (err_clr)                udf_cnt <= CNT_ONE;
        else if (udf_cnt != CNT_MAX) udf_cnt <= udf_cnt + 1'b1;
      end else if (err_clr) begin
        underflow <= 1'b0;
        udf_cnt   <= '0;
      end

`ifdef FIFO_ASSERT_EN
      if (push) begin
        a_push: assert (!full || pop)
          else $error("[FAIL] push when fifo is full at %0t", $time);
      end
      if (pop) begin
        a_pop: assert (!empty)
          else $error("[FAIL] pop when fifo is empty at %0t", $time);
      end
      a_count: assert (count <= DEPTH_C)
        else $error("[FAIL] count exceeds depth at %0t", $time);
`else
`endif
    end
  end

endmodule
`default_nettype wire
